// File: rtl/memory_buffer.sv
// Addressed DEPTH x DATA_W scratch buffer with a valid bit per entry and full/empty flags.
// Optional MEMORY_BUFFER_BYPASS_EN: same-address simultaneous write/read returns the write data.
module memory_buffer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w,
  input  logic              r,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_d, valid_q;
  logic [DATA_W-1:0] data_out_d, data_out_q;
  logic              rd_hit;

  assign rd_hit = r && valid_q[r_addr];

  always_comb begin
    valid_d = valid_q;
    // Clear on read first so a same-address write leaves the entry valid.
    if (rd_hit) valid_d[r_addr] = 1'b0;
    if (w)      valid_d[w_addr] = 1'b1;
  end

  always_comb begin
    data_out_d = data_out_q;
`ifdef MEMORY_BUFFER_BYPASS_EN
    if (w && r && (w_addr == r_addr)) begin
      data_out_d = data_in;
    end else if (rd_hit) begin
      data_out_d = mem_q[r_addr];
    end
`else
    if (rd_hit) data_out_d = mem_q[r_addr];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      data_out_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is not reset; writes are simply suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (w && rst) mem_q[w_addr] <= data_in;
  end

  assign data_out = data_out_q;
  assign full     = &valid_q;
  assign empty    = ~|valid_q;

endmodule

// File: tb/tb_memory_buffer.sv
// Self-checking bench for memory_buffer: per-cycle compare against a behavioural model
// plus directed literal checks.
module tb_memory_buffer;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          w = 1'b0, r = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] r_addr = '0, w_addr = '0;
  logic [DW-1:0] data_out;
  logic          full, empty;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  // Behavioural model
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_valid [DEPTH];
  logic [DW-1:0] m_out;
  bit            m_hit;

  memory_buffer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .w        (w),
    .r        (r),
    .data_in  (data_in),
    .r_addr   (r_addr),
    .w_addr   (w_addr),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int occupancy();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_valid[i] ? 1 : 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_out = '0;
    end else begin
      m_hit = r && m_valid[r_addr];
`ifdef MEMORY_BUFFER_BYPASS_EN
      if (w && r && w_addr == r_addr) m_out = data_in;
      else if (m_hit) m_out = m_mem[r_addr];
`else
      if (m_hit) m_out = m_mem[r_addr];
`endif
      if (m_hit) m_valid[r_addr] = 1'b0;
      if (w) begin
        m_mem[w_addr]   = data_in;
        m_valid[w_addr] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model data_out", {16'h0, data_out}, {16'h0, m_out});
      chk("model full", {31'h0, full}, {31'h0, occupancy() == DEPTH});
      chk("model empty", {31'h0, empty}, {31'h0, occupancy() == 0});
    end
  end

  // Apply one cycle of stimulus, returning at the following falling edge.
  task automatic op(input logic iw, input logic ir, input logic [DW-1:0] id,
                    input logic [AW-1:0] ira, input logic [AW-1:0] iwa);
    w = iw; r = ir; data_in = id; r_addr = ira; w_addr = iwa;
    @(negedge clk);
    w = 1'b0; r = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_out = '0;
    #1;
    chk("reset data_out", {16'h0, data_out}, 32'h0);
    chk("reset empty", {31'h0, empty}, 32'h1);
    chk("reset full", {31'h0, full}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    started = 1'b1;

    op(1'b0, 1'b1, 16'h0, 4'd0, 4'd0);
    chk("read invalid after reset", {16'h0, data_out}, 32'h0);

    // Write/readback
    op(1'b1, 1'b0, 16'h0001, 4'd0, 4'd0);
    chk("empty after first write", {31'h0, empty}, 32'h0);
    op(1'b1, 1'b0, 16'h0002, 4'd0, 4'd1);
    op(1'b1, 1'b0, 16'h0003, 4'd0, 4'd2);
    op(1'b0, 1'b1, 16'h0, 4'd0, 4'd0);
    chk("readback 0", {16'h0, data_out}, 32'h0001);
    op(1'b0, 1'b1, 16'h0, 4'd1, 4'd0);
    chk("readback 1", {16'h0, data_out}, 32'h0002);
    op(1'b0, 1'b1, 16'h0, 4'd2, 4'd0);
    chk("readback 2", {16'h0, data_out}, 32'h0003);
    chk("empty after drain", {31'h0, empty}, 32'h1);

    // Fill
    for (int i = 0; i < DEPTH; i++) begin
      op(1'b1, 1'b0, 16'hC000 + 16'(i * 7), 4'd0, 4'(i));
      if (i == DEPTH - 2) chk("not full at 15", {31'h0, full}, 32'h0);
    end
    chk("full after 16", {31'h0, full}, 32'h1);
    op(1'b0, 1'b1, 16'h0, 4'd5, 4'd0);
    chk("fill read 5", {16'h0, data_out}, 32'hC023);
    chk("full cleared", {31'h0, full}, 32'h0);

    // Empty-location read holds data_out
    op(1'b0, 1'b1, 16'h0, 4'd7, 4'd0);
    chk("fill read 7", {16'h0, data_out}, 32'hC031);
    op(1'b1, 1'b0, 16'h1234, 4'd0, 4'd9);
    op(1'b0, 1'b1, 16'h0, 4'd9, 4'd0);
    chk("read 9", {16'h0, data_out}, 32'h1234);
    op(1'b0, 1'b1, 16'h0, 4'd7, 4'd0);
    chk("invalid read holds", {16'h0, data_out}, 32'h1234);
    chk("invalid read empty", {31'h0, empty}, 32'h0);

    // Simultaneous same valid address
    op(1'b1, 1'b0, 16'hAAAA, 4'd0, 4'd3);
    op(1'b1, 1'b1, 16'h5555, 4'd3, 4'd3);
`ifdef MEMORY_BUFFER_BYPASS_EN
    chk("same addr rw", {16'h0, data_out}, 32'h5555);
`else
    chk("same addr rw", {16'h0, data_out}, 32'hAAAA);
`endif
    op(1'b0, 1'b1, 16'h0, 4'd3, 4'd0);
    chk("reread 3", {16'h0, data_out}, 32'h5555);

    // Mid-cycle asynchronous reset
    #2 rst = 1'b0;
    #1;
    chk("async rst data_out", {16'h0, data_out}, 32'h0);
    chk("async rst empty", {31'h0, empty}, 32'h1);
    chk("async rst full", {31'h0, full}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    op(1'b0, 1'b1, 16'h0, 4'd0, 4'd0);
    chk("read 0 after rst", {16'h0, data_out}, 32'h0);

    // Overwrite
    op(1'b1, 1'b0, 16'h1111, 4'd0, 4'd4);
    op(1'b1, 1'b0, 16'h2222, 4'd0, 4'd4);
    chk("overwrite occupancy", occupancy(), 32'd1);
    op(1'b0, 1'b1, 16'h0, 4'd4, 4'd0);
    chk("overwrite read", {16'h0, data_out}, 32'h2222);
    chk("overwrite empty", {31'h0, empty}, 32'h1);

    // Simultaneous same invalid address
    op(1'b1, 1'b1, 16'h7777, 4'd6, 4'd6);
`ifdef MEMORY_BUFFER_BYPASS_EN
    chk("same invalid rw", {16'h0, data_out}, 32'h7777);
`else
    chk("same invalid rw", {16'h0, data_out}, 32'h2222);
`endif
    chk("same invalid empty", {31'h0, empty}, 32'h0);

    // Simultaneous different addresses
    op(1'b1, 1'b1, 16'h0BBB, 4'd6, 4'd10);
    chk("diff addr read", {16'h0, data_out}, 32'h7777);
    op(1'b0, 1'b1, 16'h0, 4'd10, 4'd0);
    chk("diff addr write", {16'h0, data_out}, 32'h0BBB);
    chk("final empty", {31'h0, empty}, 32'h1);

    @(negedge clk);
    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
